logic_slice_responder: RTL and testbench

- Responder end of the ALU operand/result interface: accepts a 64-bit operand pair plus logic opcode from the requesting datapath and returns the bitwise result and flags.
- Multi-cycle: processes SLICE_W bits per cycle, trading latency for a narrow logic array.
- Sits beside the 64-bit bitwise units in the lab ALU and is driven by the ALU control sequencer.

---
 rtl/logic_slice_responder_pkg.sv | 21 ++
 rtl/logic_slice_responder_if.sv | 43 ++++
 rtl/logic_slice_responder_op.sv | 27 ++
 rtl/logic_slice_responder.sv | 122 ++++++++++++
 tb/tb_logic_slice_responder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_slice_responder_pkg.sv
// rtl/logic_slice_responder_pkg.sv - shared opcodes, FSM states and default sizes
// Purpose: common definitions for the sliced bitwise logic responder.
// Ports: none (package).
package logic_slice_responder_pkg;

  localparam int DEF_WIDTH   = 64;
  localparam int DEF_SLICE_W = 8;
  localparam int DEF_OPW     = 2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/logic_slice_responder_if.sv
// rtl/logic_slice_responder_if.sv - request/response bundle for the sliced logic responder
// Purpose: groups the operand request and result response handshakes.
// Signals: req_valid/req_ready/req_a/req_b/req_op (request),
//          resp_valid/resp_ready/resp_result/resp_zero (response),
//          resp_parity only when LOGIC_SLICE_PARITY_EN is defined.
// Modports: master = requesting datapath, slave = responder.
interface logic_slice_responder_if #(
  parameter int WIDTH = 64,
  parameter int OPW   = 2
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [OPW-1:0]   req_op;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
`ifdef LOGIC_SLICE_PARITY_EN
  logic             resp_parity;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_parity
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_parity
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero
  );
`endif
endinterface

// File: rtl/logic_slice_responder_op.sv
// rtl/logic_slice_responder_op.sv - combinational SLICE_W-wide bitwise operator
// Purpose: y = op(a, b) for AND / OR / XOR / NOR.
// Ports: a, b (SLICE_W) operands; op (OPW) opcode; y (SLICE_W) result.
module logic_slice_op
  import logic_slice_responder_pkg::*;
#(
  parameter int SLICE_W = DEF_SLICE_W,
  parameter int OPW     = DEF_OPW
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [OPW-1:0]     op,
  output logic [SLICE_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_slice_responder.sv
// rtl/logic_slice_responder.sv - multi-cycle sliced bitwise logic responder (top)
// Purpose: accepts a WIDTH-bit operand pair and opcode, evaluates SLICE_W bits
//          per BUSY cycle and returns the result with a zero flag.
// Ports: clk, rst (async active-high); bus (slave modport of
//        logic_slice_responder_if); busy (state != IDLE).
// Optional: LOGIC_SLICE_PARITY_EN adds bus.resp_parity = ^resp_result.
module logic_slice_responder
  import logic_slice_responder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W,
  parameter int OPW     = DEF_OPW
) (
  input  logic                    clk,
  input  logic                    rst,
  logic_slice_responder_if.slave  bus,
  output logic                    busy
);

  localparam int NSLICES = WIDTH / SLICE_W;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q, result_next;
  logic [OPW-1:0]     op_q;
  logic               zero_q;
  logic               req_ready, resp_valid, accept, last_slice;
  logic [31:0]        base;
  logic [SLICE_W-1:0] slice_res;

  assign base = 32'(cnt_q) * 32'(SLICE_W);

  logic_slice_op #(
    .SLICE_W (SLICE_W),
    .OPW     (OPW)
  ) u_op (
    .a  (a_q[base +: SLICE_W]),
    .b  (b_q[base +: SLICE_W]),
    .op (op_q),
    .y  (slice_res)
  );

  // Result with the current slice merged in; the zero flag on the last
  // slice must see the final slice, so it is derived from this value.
  always_comb begin
    result_next = result_q;
    result_next[base +: SLICE_W] = slice_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    last_slice = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        accept    = bus.req_valid;
        if (bus.req_valid) state_d = S_BUSY;
      end
      S_BUSY: begin
        last_slice = (cnt_q == LAST_CNT);
        if (last_slice) state_d = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      a_q      <= bus.req_a;
      b_q      <= bus.req_b;
      op_q     <= bus.req_op;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (state_q == S_BUSY) begin
      result_q <= result_next;
      // Counter stops on the last slice rather than wrapping.
      if (last_slice) zero_q <= (result_next == '0);
      else            cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

`ifdef LOGIC_SLICE_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    parity_q <= 1'b0;
    else if (accept)            parity_q <= 1'b0;
    else if (state_q == S_BUSY) parity_q <= parity_q ^ (^slice_res);
  end

  assign bus.resp_parity = parity_q;
`endif

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_result = result_q;
  assign bus.resp_zero   = zero_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_logic_slice_responder.sv
// tb/tb_logic_slice_responder.sv - directed self-checking bench for logic_slice_responder
module tb_logic_slice_responder;

  logic clk;
  logic rst;
  logic busy;
  int   cmp_cnt;
  int   mis_cnt;

  logic_slice_responder_if #(.WIDTH(64), .OPW(2)) bif ();

  logic_slice_responder dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bif),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // Handshake a request, optionally scramble operands once BUSY, then wait
  // for resp_valid. lat = cycles from accept edge to resp_valid (20 = none).
  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] op, input bit scramble, output int lat);
    @(negedge clk);
    bif.req_valid = 1'b1;
    bif.req_a     = a;
    bif.req_b     = b;
    bif.req_op    = op;
    @(negedge clk);
    bif.req_valid = 1'b0;
    if (scramble) begin
      bif.req_a = '1;
      bif.req_b = '1;
    end
    lat = 0;
    while (!bif.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    bif.resp_ready = 1'b1;
    @(negedge clk);
    bif.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    bit seen;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (bif.req_ready !== 1'b1 || bif.resp_valid !== 1'b0 || busy !== 1'b0) begin
      mis_cnt++;
      $display("FAIL reset_init: ready/valid/busy got %b%b%b required 100",
               bif.req_ready, bif.resp_valid, busy);
    end
    cmp_cnt++;
    if (bif.resp_result !== 64'h0 || bif.resp_zero !== 1'b0) begin
      mis_cnt++;
      $display("FAIL reset_init_result: got %h/%b required 0/0", bif.resp_result, bif.resp_zero);
    end
    // Abandon an AND mid-BUSY.
    bif.req_valid = 1'b1;
    bif.req_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    bif.req_b     = 64'hFFFF_FFFF_FFFF_FFFF;
    bif.req_op    = 2'b00;
    @(negedge clk);
    bif.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (busy !== 1'b1) begin
      mis_cnt++;
      $display("FAIL reset_pre_busy: busy got %b required 1", busy);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (bif.req_ready !== 1'b1 || bif.resp_valid !== 1'b0 || busy !== 1'b0) begin
      mis_cnt++;
      $display("FAIL reset_mid: ready/valid/busy got %b%b%b required 100",
               bif.req_ready, bif.resp_valid, busy);
    end
    cmp_cnt++;
    if (bif.resp_result !== 64'h0) begin
      mis_cnt++;
      $display("FAIL reset_mid_result: got %h required 0", bif.resp_result);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bif.resp_valid) seen = 1'b1;
    end
    cmp_cnt++;
    if (seen !== 1'b0) begin
      mis_cnt++;
      $display("FAIL reset_no_resp: resp_valid seen got %b required 0", seen);
    end
    lat = 0;
  endtask

  task automatic test_and();
    int lat;
    send(64'hFFFF_0000_F0F0_1234, 64'h0F0F_FFFF_FF00_FFFF, 2'b00, 1'b0, lat);
    cmp_cnt++;
    if (lat !== 8) begin
      mis_cnt++;
      $display("FAIL and_latency: got %0d required 8", lat);
    end
    cmp_cnt++;
    if (bif.resp_result !== 64'h0F0F_0000_F000_1234) begin
      mis_cnt++;
      $display("FAIL and_result: got %h required 0f0f0000f0001234", bif.resp_result);
    end
    cmp_cnt++;
    if (bif.resp_zero !== 1'b0) begin
      mis_cnt++;
      $display("FAIL and_zero: got %b required 0", bif.resp_zero);
    end
    take();
  endtask

  task automatic test_zero_flag();
    logic [63:0] a_v [3];
    logic [63:0] b_v [3];
    logic [1:0]  o_v [3];
    logic [63:0] r_v [3];
    logic        z_v [3];
    int lat;
    a_v[0] = 64'hAAAA_AAAA_AAAA_AAAA; b_v[0] = 64'h5555_5555_5555_5555; o_v[0] = 2'b00;
    r_v[0] = 64'h0;                   z_v[0] = 1'b1;
    a_v[1] = 64'hAAAA_AAAA_AAAA_AAAA; b_v[1] = 64'h5555_5555_5555_5555; o_v[1] = 2'b10;
    r_v[1] = 64'hFFFF_FFFF_FFFF_FFFF; z_v[1] = 1'b0;
    a_v[2] = 64'hFFFF_FFFF_FFFF_FFFF; b_v[2] = 64'hFFFF_FFFF_FFFF_FFFF; o_v[2] = 2'b11;
    r_v[2] = 64'h0;                   z_v[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(a_v[i], b_v[i], o_v[i], 1'b0, lat);
      cmp_cnt++;
      if (bif.resp_result !== r_v[i]) begin
        mis_cnt++;
        $display("FAIL zero_result[%0d]: got %h required %h", i, bif.resp_result, r_v[i]);
      end
      cmp_cnt++;
      if (bif.resp_zero !== z_v[i]) begin
        mis_cnt++;
        $display("FAIL zero_flag[%0d]: got %b required %b", i, bif.resp_zero, z_v[i]);
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(64'h1234_5678_9ABC_DEF0, 64'hFF00_FF00_FF00_FF00, 2'b01, 1'b0, lat);
    // Second request is held while the first response is stalled.
    bif.req_valid = 1'b1;
    bif.req_a     = 64'h00FF_00FF_00FF_00FF;
    bif.req_b     = 64'h0F0F_0F0F_0F0F_0F0F;
    bif.req_op    = 2'b10;
    for (int i = 0; i < 5; i++) begin
      cmp_cnt++;
      if (bif.resp_valid !== 1'b1 || bif.req_ready !== 1'b0 ||
          bif.resp_result !== 64'hFF34_FF78_FFBC_FFF0) begin
        mis_cnt++;
        $display("FAIL bp_hold[%0d]: valid/ready/result got %b/%b/%h required 1/0/ff34ff78ffbcfff0",
                 i, bif.resp_valid, bif.req_ready, bif.resp_result);
      end
      @(negedge clk);
    end
    take();
    cmp_cnt++;
    if (bif.resp_valid !== 1'b0 || bif.req_ready !== 1'b1 || busy !== 1'b0) begin
      mis_cnt++;
      $display("FAIL bp_after_take: valid/ready/busy got %b%b%b required 010",
               bif.resp_valid, bif.req_ready, busy);
    end
    cmp_cnt++;
    if (bif.resp_result !== 64'hFF34_FF78_FFBC_FFF0) begin
      mis_cnt++;
      $display("FAIL bp_retain: got %h required ff34ff78ffbcfff0", bif.resp_result);
    end
    @(negedge clk);
    bif.req_valid = 1'b0;
    cmp_cnt++;
    if (busy !== 1'b1 || bif.req_ready !== 1'b0) begin
      mis_cnt++;
      $display("FAIL bp_second_accept: busy/ready got %b%b required 10", busy, bif.req_ready);
    end
    lat = 0;
    while (!bif.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    cmp_cnt++;
    if (lat !== 8 || bif.resp_result !== 64'h0FF0_0FF0_0FF0_0FF0) begin
      mis_cnt++;
      $display("FAIL bp_second_result: lat/result got %0d/%h required 8/0ff00ff00ff00ff0",
               lat, bif.resp_result);
    end
    take();
  endtask

  task automatic test_input_change();
    int lat;
    send(64'h1, 64'h2, 2'b01, 1'b1, lat);
    cmp_cnt++;
    if (bif.resp_result !== 64'h3) begin
      mis_cnt++;
      $display("FAIL input_change_result: got %h required 3", bif.resp_result);
    end
    cmp_cnt++;
    if (bif.resp_zero !== 1'b0 || lat !== 8) begin
      mis_cnt++;
      $display("FAIL input_change_flags: zero/lat got %b/%0d required 0/8", bif.resp_zero, lat);
    end
    take();
  endtask

`ifdef LOGIC_SLICE_PARITY_EN
  task automatic test_parity();
    int lat;
    send(64'h1, 64'h0, 2'b10, 1'b0, lat);
    cmp_cnt++;
    if (bif.resp_parity !== 1'b1) begin
      mis_cnt++;
      $display("FAIL parity_one: got %b required 1", bif.resp_parity);
    end
    take();
    send(64'h3, 64'h0, 2'b10, 1'b0, lat);
    cmp_cnt++;
    if (bif.resp_parity !== 1'b0) begin
      mis_cnt++;
      $display("FAIL parity_two: got %b required 0", bif.resp_parity);
    end
    take();
  endtask
`endif

  initial begin
    cmp_cnt = 0;
    mis_cnt = 0;
    rst = 1'b1;
    bif.req_valid  = 1'b0;
    bif.req_a      = '0;
    bif.req_b      = '0;
    bif.req_op     = '0;
    bif.resp_ready = 1'b0;
    test_reset();
    test_and();
    test_zero_flag();
    test_backpressure();
    test_input_change();
`ifdef LOGIC_SLICE_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
